// File: rtl/des_result_packer_pkg.sv
// Shared types and widths for the DES result packer and its FIFO.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int PIPE_W      = 32;

  typedef enum logic [0:0] {
    S_LO = 1'b0,
    S_HI = 1'b1
  } half_sel_t;

  // Width of a word counter that must hold 0..2*depth inclusive.
  function automatic int wordCountWidth(input int depth);
    return $clog2(2 * depth) + 1;
  endfunction

endpackage

// File: rtl/des_result_packer_fifo.sv
// Synchronous DEPTH x 64 result FIFO with a registered head word.
module des_packer_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [DES_BLOCK_W-1:0]    din,
  output logic [DES_BLOCK_W-1:0]    head,
  output logic [$clog2(DEPTH):0]    entries,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = PW + 1;

  logic [DES_BLOCK_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]          wrPtr_r;
  logic [PW-1:0]          rdPtr_r;
  logic [EW-1:0]          entries_r;
  logic [DES_BLOCK_W-1:0] head_r;
  logic                   doPush_s;
  logic                   doPop_s;

  assign full     = (entries_r == EW'(DEPTH));
  assign empty    = (entries_r == {EW{1'b0}});
  assign doPush_s = push && !full && !flush;
  assign doPop_s  = pop && !empty && !flush;
  assign entries  = entries_r;
  assign head     = head_r;

  // Storage array; left without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (doPush_s) begin
      mem_r[wrPtr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wrPtr_r   <= {PW{1'b0}};
      rdPtr_r   <= {PW{1'b0}};
      entries_r <= {EW{1'b0}};
    end else begin
      if (doPush_s) wrPtr_r <= wrPtr_r + PW'(1);
      if (doPop_s)  rdPtr_r <= rdPtr_r + PW'(1);
      entries_r <= entries_r + EW'(doPush_s) - EW'(doPop_s);
    end
  end

  // Head register: new data bypasses into an emptying FIFO, else prefetch the next slot.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      head_r <= {DES_BLOCK_W{1'b0}};
    end else if (doPush_s && (empty || (doPop_s && entries_r == EW'(1)))) begin
      head_r <= din;
    end else if (doPop_s) begin
      head_r <= mem_r[rdPtr_r + PW'(1)];
    end
  end

endmodule

// File: rtl/des_result_packer.sv
// Buffers 64-bit DES results and serializes them as 32-bit words, low half first.
// Optional status outputs (err_ovf, err_udf, total_words) under DES_RESULT_PACKER_STATUS_EN.
module des_result_packer
  import des_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [DES_BLOCK_W-1:0]            in_data,
  output logic                              in_ready,
  input  logic                              out_read,
  output logic [PIPE_W-1:0]                 out_data,
  output logic                              out_empty,
  output logic [wordCountWidth(DEPTH)-1:0]  word_count,
  output logic                              blk_ready
`ifdef DES_RESULT_PACKER_STATUS_EN
  ,
  output logic                              err_ovf,
  output logic                              err_udf,
  output logic [31:0]                       total_words
`endif
);

  localparam int EW  = $clog2(DEPTH) + 1;
  localparam int WCW = wordCountWidth(DEPTH);

  half_sel_t              state_r;
  half_sel_t              nextState_s;
  logic [DES_BLOCK_W-1:0] head_s;
  logic [EW-1:0]          entries_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   rdValid_s;
  logic [WCW-1:0]         wordCount_s;
  logic [EW-1:0]          nextEntries_s;
  logic [WCW-1:0]         nextWordCount_s;
  logic                   blkReady_r;

  assign push_s    = in_valid && !full_s;
  assign rdValid_s = out_read && !out_empty;
  assign pop_s     = rdValid_s && (state_r == S_HI);

  des_packer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush),
    .din     (in_data),
    .head    (head_s),
    .entries (entries_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Half-select state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_LO;
    end else if (flush) begin
      state_r <= S_LO;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Half-select next state: every accepted read toggles the half.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      S_LO: begin
        if (rdValid_s) nextState_s = S_HI;
        else           nextState_s = S_LO;
      end
      S_HI: begin
        if (rdValid_s) nextState_s = S_LO;
        else           nextState_s = S_HI;
      end
      default: nextState_s = S_LO;
    endcase
  end

  // Read-side outputs derived from FIFO occupancy, head and half-select.
  always_comb begin
    wordCount_s = {entries_s, 1'b0} - {{(WCW-1){1'b0}}, (state_r == S_HI)};
    word_count  = wordCount_s;
    out_empty   = (wordCount_s == {WCW{1'b0}});
    in_ready    = !full_s;
    if (out_empty) begin
      out_data = {PIPE_W{1'b0}};
    end else if (state_r == S_HI) begin
      out_data = head_s[DES_BLOCK_W-1:PIPE_W];
    end else begin
      out_data = head_s[PIPE_W-1:0];
    end
  end

  // Occupancy after this edge, so blk_ready lines up with word_count.
  always_comb begin
    if (flush) begin
      nextEntries_s   = {EW{1'b0}};
      nextWordCount_s = {WCW{1'b0}};
    end else begin
      nextEntries_s   = entries_s + EW'(push_s) - EW'(pop_s);
      nextWordCount_s = {nextEntries_s, 1'b0} - {{(WCW-1){1'b0}}, (nextState_s == S_HI)};
    end
  end

  // Block-ready flag register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blkReady_r <= 1'b0;
    end else begin
      blkReady_r <= (nextWordCount_s >= WCW'(BLOCK_WORDS));
    end
  end

  assign blk_ready = blkReady_r;

`ifdef DES_RESULT_PACKER_STATUS_EN
  logic        errOvf_r;
  logic        errUdf_r;
  logic [31:0] totalWords_r;

  // Sticky protocol errors and read word counter.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      errOvf_r     <= 1'b0;
      errUdf_r     <= 1'b0;
      totalWords_r <= 32'd0;
    end else begin
      if (in_valid && full_s)   errOvf_r <= 1'b1;
      if (out_read && out_empty) errUdf_r <= 1'b1;
      if (rdValid_s)            totalWords_r <= totalWords_r + 32'd1;
    end
  end

  assign err_ovf     = errOvf_r;
  assign err_udf     = errUdf_r;
  assign total_words = totalWords_r;
`endif

endmodule
